// File: rtl/ram_wr_sched.sv
// Write-side scheduler for a dual-write RAM: zero-clears the array after reset or on request,
// then arbitrates requesters round-robin onto one or two write ports with same-address avoidance.
module ram_wr_sched #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 3,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DUAL_WR   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*ADDRWIDTH-1:0] req_addr,
    input  logic [NREQ*DATAWIDTH-1:0] req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      init_start,
    output logic                      busy,
    output logic                      init_done,
    output logic                      en_w1_n,
    output logic [ADDRWIDTH-1:0]      addr_w1,
    output logic [DATAWIDTH-1:0]      data_w1,
    output logic                      en_w2_n,
    output logic [ADDRWIDTH-1:0]      addr_w2,
    output logic [DATAWIDTH-1:0]      data_w2
);

    localparam int unsigned DEPTH = 1 << ADDRWIDTH;
    localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {CLR, RUN} state_e;

    state_e                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                   en_w1_n_q, en_w1_n_d, en_w2_n_q, en_w2_n_d;
    logic [ADDRWIDTH-1:0]   addr_w1_q, addr_w1_d, addr_w2_q, addr_w2_d;
    logic [DATAWIDTH-1:0]   data_w1_q, data_w1_d, data_w2_q, data_w2_d;
    logic                   init_done_q, init_done_d;

    logic                   found1_c, found2_c;
    int unsigned            g1_c, g2_c;
    logic [NREQ-1:0]        ready_c;

    // Circular scan from rr_ptr: first valid wins port 1, next valid with a different address wins port 2
    always_comb begin
        int unsigned idx;
        found1_c = 1'b0;
        found2_c = 1'b0;
        g1_c     = 0;
        g2_c     = 0;
        ready_c  = '0;
        idx      = 0;
        if (state_q == RUN && !init_start) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                if (req_valid[idx]) begin
                    if (!found1_c) begin
                        found1_c = 1'b1;
                        g1_c     = idx;
                    end else if (DUAL_WR != 0 && !found2_c &&
                                 req_addr[idx*ADDRWIDTH +: ADDRWIDTH] !=
                                 req_addr[g1_c*ADDRWIDTH +: ADDRWIDTH]) begin
                        found2_c = 1'b1;
                        g2_c     = idx;
                    end
                end
            end
            if (found1_c) ready_c[g1_c] = 1'b1;
            if (found2_c) ready_c[g2_c] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        en_w1_n_d   = 1'b1;
        addr_w1_d   = addr_w1_q;
        data_w1_d   = data_w1_q;
        en_w2_n_d   = 1'b1;
        addr_w2_d   = addr_w2_q;
        data_w2_d   = data_w2_q;
        init_done_d = 1'b0;
        case (state_q)
            CLR: begin
                en_w1_n_d = 1'b0;
                addr_w1_d = clr_cnt_q;
                data_w1_d = '0;
                if (DUAL_WR != 0) begin
                    en_w2_n_d = 1'b0;
                    addr_w2_d = clr_cnt_q + ADDRWIDTH'(1);
                    data_w2_d = '0;
                    clr_cnt_d = clr_cnt_q + ADDRWIDTH'(2);
                    if (clr_cnt_q == ADDRWIDTH'(DEPTH - 2)) begin
                        state_d     = RUN;
                        init_done_d = 1'b1;
                        clr_cnt_d   = '0;
                    end
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDRWIDTH'(1);
                    if (clr_cnt_q == ADDRWIDTH'(DEPTH - 1)) begin
                        state_d     = RUN;
                        init_done_d = 1'b1;
                        clr_cnt_d   = '0;
                    end
                end
            end
            RUN: begin
                if (init_start) begin
                    state_d   = CLR;
                    clr_cnt_d = '0;
                end else if (found1_c) begin
                    en_w1_n_d = 1'b0;
                    addr_w1_d = req_addr[g1_c*ADDRWIDTH +: ADDRWIDTH];
                    data_w1_d = req_data[g1_c*DATAWIDTH +: DATAWIDTH];
                    rr_ptr_d  = PW'((g1_c + 1) % NREQ);
                    if (found2_c) begin
                        en_w2_n_d = 1'b0;
                        addr_w2_d = req_addr[g2_c*ADDRWIDTH +: ADDRWIDTH];
                        data_w2_d = req_data[g2_c*DATAWIDTH +: DATAWIDTH];
                        rr_ptr_d  = PW'((g2_c + 1) % NREQ);
                    end
                end
            end
            default: state_d = CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLR;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            en_w1_n_q   <= 1'b1;
            addr_w1_q   <= '0;
            data_w1_q   <= '0;
            en_w2_n_q   <= 1'b1;
            addr_w2_q   <= '0;
            data_w2_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            en_w1_n_q   <= en_w1_n_d;
            addr_w1_q   <= addr_w1_d;
            data_w1_q   <= data_w1_d;
            en_w2_n_q   <= en_w2_n_d;
            addr_w2_q   <= addr_w2_d;
            data_w2_q   <= data_w2_d;
            init_done_q <= init_done_d;
        end
    end

    assign req_ready = ready_c;
    assign busy      = (state_q == CLR);
    assign init_done = init_done_q;
    assign en_w1_n   = en_w1_n_q;
    assign addr_w1   = addr_w1_q;
    assign data_w1   = data_w1_q;
    assign en_w2_n   = en_w2_n_q;
    assign addr_w2   = addr_w2_q;
    assign data_w2   = data_w2_q;

endmodule

// File: tb/tb_ram_wr_sched.sv
// Directed bench for ram_wr_sched: a dual-port instance with a RAM model, plus a single-port instance.
module tb_ram_wr_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [31:0] req_data;
    logic        init_start;

    logic [3:0]  req_ready_a;
    logic        busy_a, init_done_a, en_w1_n_a, en_w2_n_a;
    logic [2:0]  addr_w1_a, addr_w2_a;
    logic [7:0]  data_w1_a, data_w2_a;

    logic [3:0]  req_ready_b;
    logic        busy_b, init_done_b, en_w1_n_b, en_w2_n_b;
    logic [2:0]  addr_w1_b, addr_w2_b;
    logic [7:0]  data_w1_b, data_w2_b;

    logic [7:0]  mem [8] = '{default: 8'hFF};

    int checks = 0;
    int errors = 0;

    ram_wr_sched #(.DATAWIDTH(8), .ADDRWIDTH(3), .NREQ(4), .DUAL_WR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready_a), .init_start(init_start),
        .busy(busy_a), .init_done(init_done_a),
        .en_w1_n(en_w1_n_a), .addr_w1(addr_w1_a), .data_w1(data_w1_a),
        .en_w2_n(en_w2_n_a), .addr_w2(addr_w2_a), .data_w2(data_w2_a)
    );

    ram_wr_sched #(.DATAWIDTH(8), .ADDRWIDTH(3), .NREQ(4), .DUAL_WR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(4'b0), .req_addr(12'b0),
        .req_data(32'b0), .req_ready(req_ready_b), .init_start(1'b0),
        .busy(busy_b), .init_done(init_done_b),
        .en_w1_n(en_w1_n_b), .addr_w1(addr_w1_b), .data_w1(data_w1_b),
        .en_w2_n(en_w2_n_b), .addr_w2(addr_w2_b), .data_w2(data_w2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!en_w1_n_a) mem[addr_w1_a] <= data_w1_a;
        if (!en_w2_n_a) mem[addr_w2_a] <= data_w2_a;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [2:0] a, input logic [7:0] d);
        req_addr[i*3 +: 3] = a;
        req_data[i*8 +: 8] = d;
    endtask

    task automatic chk_p1(input string tag, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_en1"}, 32'(en_w1_n_a), 32'd0);
        chk({tag, "_a1"}, 32'(addr_w1_a), 32'(a));
        chk({tag, "_d1"}, 32'(data_w1_a), 32'(d));
    endtask

    task automatic chk_p2(input string tag, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_en2"}, 32'(en_w2_n_a), 32'd0);
        chk({tag, "_a2"}, 32'(addr_w2_a), 32'(a));
        chk({tag, "_d2"}, 32'(data_w2_a), 32'(d));
    endtask

    initial begin
        rst_n      = 1'b0;
        init_start = 1'b0;
        req_valid  = 4'b1111;
        req_addr   = {3'd3, 3'd2, 3'd1, 3'd0};
        req_data   = 32'hD3D2D1D0;
        #12;
        // Reset state
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_ready", 32'(req_ready_a), 32'd0);
        chk("rst_en1", 32'(en_w1_n_a), 32'd1);
        chk("rst_en2", 32'(en_w2_n_a), 32'd1);
        chk("rst_a1", 32'(addr_w1_a), 32'd0);
        chk("rst_d2", 32'(data_w2_a), 32'd0);
        chk("rst_done", 32'(init_done_a), 32'd0);
        chk("rst_b_en1", 32'(en_w1_n_b), 32'd1);
        chk("rst_b_busy", 32'(busy_b), 32'd1);
        rst_n = 1'b1;

        // Post-reset clear: dual-port instance 4 cycles, single-port instance 8 cycles
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 4) begin
                chk_p1("clr", 3'(2*(k-1)), 8'h00);
                chk_p2("clr", 3'(2*k-1), 8'h00);
                chk("clr_busy", 32'(busy_a), 32'(k < 4));
                chk("clr_done", 32'(init_done_a), 32'(k == 4));
                if (k < 4) chk("clr_ready", 32'(req_ready_a), 32'd0);
                if (k == 3) req_valid = 4'b0000;
            end else begin
                chk("idle_en1", 32'(en_w1_n_a), 32'd1);
                chk("idle_en2", 32'(en_w2_n_a), 32'd1);
                chk("idle_done", 32'(init_done_a), 32'd0);
            end
            chk("b_en1", 32'(en_w1_n_b), 32'd0);
            chk("b_a1", 32'(addr_w1_b), 32'(k-1));
            chk("b_d1", 32'(data_w1_b), 32'd0);
            chk("b_en2", 32'(en_w2_n_b), 32'd1);
            chk("b_busy", 32'(busy_b), 32'(k < 8));
            chk("b_done", 32'(init_done_b), 32'(k == 8));
        end
        chk("b_a2_held", 32'(addr_w2_b), 32'd0);
        chk("b_d2_held", 32'(data_w2_b), 32'd0);
        chk("b_ready", 32'(req_ready_b), 32'd0);
        for (int a = 0; a < 8; a++) chk("clr_mem", 32'(mem[a]), 32'd0);

        // Two distinct requests from rr_ptr=0
        set_req(0, 3'd2, 8'hAA);
        set_req(2, 3'd5, 8'h55);
        req_valid = 4'b0101;
        #1 chk("two_ready", 32'(req_ready_a), 32'b0101);
        tick();
        chk_p1("two", 3'd2, 8'hAA);
        chk_p2("two", 3'd5, 8'h55);

        // rr_ptr now 3: same address on req0/req3 must favour req3
        set_req(0, 3'd6, 8'h60);
        set_req(3, 3'd6, 8'h63);
        req_valid = 4'b1001;
        #1 chk("rr3_ready", 32'(req_ready_a), 32'b1000);
        tick();
        chk_p1("rr3", 3'd6, 8'h63);
        chk("rr3_en2", 32'(en_w2_n_a), 32'd1);
        chk("rr3_a2_hold", 32'(addr_w2_a), 32'd5);
        chk("rr3_d2_hold", 32'(data_w2_a), 32'h55);

        // Same-address conflict, rr_ptr=0
        set_req(1, 3'd4, 8'h11);
        set_req(3, 3'd4, 8'h33);
        req_valid = 4'b1010;
        #1 chk("conf1_ready", 32'(req_ready_a), 32'b0010);
        tick();
        chk_p1("conf1", 3'd4, 8'h11);
        chk("conf1_en2", 32'(en_w2_n_a), 32'd1);
        req_valid = 4'b1000;
        #1 chk("conf2_ready", 32'(req_ready_a), 32'b1000);
        tick();
        chk_p1("conf2", 3'd4, 8'h33);
        chk("conf2_en2", 32'(en_w2_n_a), 32'd1);
        req_valid = 4'b0000;
        tick();
        chk("none_en1", 32'(en_w1_n_a), 32'd1);
        chk("none_en2", 32'(en_w2_n_a), 32'd1);
        chk("mem4", 32'(mem[4]), 32'h33);
        chk("mem2", 32'(mem[2]), 32'hAA);
        chk("mem5", 32'(mem[5]), 32'h55);
        chk("mem6", 32'(mem[6]), 32'h63);

        // Fairness: all four valid with distinct addresses
        for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'(8'hC0 + i));
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1 chk("fair_ready", 32'(req_ready_a), (c % 2 == 0) ? 32'b0011 : 32'b1100);
            tick();
            chk_p1("fair", 3'((c % 2) * 2), 8'(8'hC0 + (c % 2) * 2));
            chk_p2("fair", 3'((c % 2) * 2 + 1), 8'(8'hC1 + (c % 2) * 2));
        end

        // init_start while req0 is valid
        set_req(0, 3'd2, 8'h5A);
        req_valid  = 4'b0001;
        init_start = 1'b1;
        #1 chk("init_ready", 32'(req_ready_a), 32'd0);
        tick();
        init_start = 1'b0;
        chk("init_en1", 32'(en_w1_n_a), 32'd1);
        chk("init_en2", 32'(en_w2_n_a), 32'd1);
        chk("init_busy", 32'(busy_a), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            #1 chk("reclr_ready", 32'(req_ready_a), 32'd0);
            tick();
            chk_p1("reclr", 3'(2*(k-1)), 8'h00);
            chk_p2("reclr", 3'(2*k-1), 8'h00);
            chk("reclr_busy", 32'(busy_a), 32'(k < 4));
            chk("reclr_done", 32'(init_done_a), 32'(k == 4));
        end
        #1 chk("post_ready", 32'(req_ready_a), 32'b0001);
        tick();
        chk_p1("post", 3'd2, 8'h5A);
        chk("post_en2", 32'(en_w2_n_a), 32'd1);
        for (int a = 0; a < 8; a++) chk("reclr_mem", 32'(mem[a]), 32'd0);
        req_valid = 4'b0000;
        tick();
        chk("post_mem2", 32'(mem[2]), 32'h5A);

        // Asynchronous reset in the middle of a clear
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        chk_p1("mid", 3'd0, 8'h00);
        tick();
        chk_p1("mid", 3'd2, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_en1", 32'(en_w1_n_a), 32'd1);
        chk("arst_en2", 32'(en_w2_n_a), 32'd1);
        chk("arst_a1", 32'(addr_w1_a), 32'd0);
        chk("arst_a2", 32'(addr_w2_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd1);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_p1("restart", 3'(2*(k-1)), 8'h00);
            chk_p2("restart", 3'(2*k-1), 8'h00);
            chk("restart_done", 32'(init_done_a), 32'(k == 4));
        end
        tick();
        chk("final_done", 32'(init_done_a), 32'd0);
        chk("final_busy", 32'(busy_a), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
